// File: rtl/servant_mdu.sv
// Sequential RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, fixed latency for every op and operand.
module servant_mdu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_mdu_rs1,
  input  logic [31:0] i_mdu_rs2,
  input  logic [2:0]  i_mdu_op,
  input  logic        i_mdu_valid,
  output logic        o_mdu_ready,
  output logic [31:0] o_mdu_rd
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        armed;
  logic [2:0]  op;
  logic        neg;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start;

  logic        sgn1, sgn2, neg_in;
  logic [31:0] mag1, mag2;
  logic [32:0] sum, add_v, shifted, diff;
  logic        ge;
  logic [31:0] hi_nxt, lo_nxt;
  logic [63:0] prod, prod_s;
  logic [31:0] div_v, div_s, result;

  assign start = (state == IDLE) && i_mdu_valid && armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops run on magnitudes; neg records whether the final value is negated.
  // A signed divide by zero must not be negated so it still yields all ones.
  always_comb begin
    sgn1   = 1'b0;
    sgn2   = 1'b0;
    neg_in = 1'b0;
    if (i_mdu_op[2]) begin
      sgn1   = i_mdu_rs1[31] & ~i_mdu_op[0];
      sgn2   = i_mdu_rs2[31] & ~i_mdu_op[0];
      neg_in = i_mdu_op[1] ? sgn1 : ((sgn1 ^ sgn2) & (|i_mdu_rs2));
    end else begin
      sgn1   = i_mdu_rs1[31] & (i_mdu_op[1:0] == 2'b01 || i_mdu_op[1:0] == 2'b10);
      sgn2   = i_mdu_rs2[31] & (i_mdu_op[1:0] == 2'b01);
      neg_in = sgn1 ^ sgn2;
    end
    mag1 = sgn1 ? -i_mdu_rs1 : i_mdu_rs1;
    mag2 = sgn2 ? -i_mdu_rs2 : i_mdu_rs2;
  end

  // Multiply keeps {hi,lo} as partial product + remaining multiplier;
  // divide keeps hi as partial remainder and shifts quotient bits into lo.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, mcand};
    add_v   = lo[0] ? sum : {1'b0, hi};
    shifted = {hi, lo[31]};
    diff    = shifted - {1'b0, mcand};
    ge      = shifted >= {1'b0, mcand};
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (op[2]) begin
      hi_nxt = ge ? diff[31:0] : shifted[31:0];
      lo_nxt = {lo[30:0], ge};
    end else begin
      hi_nxt = add_v[32:1];
      lo_nxt = {add_v[0], lo[31:1]};
    end
  end

  always_comb begin
    prod   = {hi, lo};
    prod_s = neg ? -prod : prod;
    div_v  = op[1] ? hi : lo;
    div_s  = neg ? -div_v : div_v;
    if (op[2])              result = div_s;
    else if (op[1:0] == 2'b00) result = prod_s[31:0];
    else                    result = prod_s[63:32];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= 5'd0;
      armed       <= 1'b1;
      op          <= 3'd0;
      neg         <= 1'b0;
      mcand       <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      o_mdu_ready <= 1'b0;
      o_mdu_rd    <= 32'd0;
    end else begin
      if (!i_mdu_valid)  armed <= 1'b1;
      else if (start)    armed <= 1'b0;
      o_mdu_ready <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          op    <= i_mdu_op;
          neg   <= neg_in;
          cnt   <= 5'd0;
          hi    <= 32'd0;
          mcand <= i_mdu_op[2] ? mag2 : mag1;
          lo    <= i_mdu_op[2] ? mag1 : mag2;
        end
        BUSY: begin
          cnt <= cnt + 5'd1;
          hi  <= hi_nxt;
          lo  <= lo_nxt;
        end
        DONE: o_mdu_rd <= result;
        default: ;
      endcase
    end
  end

endmodule
